downsample_engine: RTL
======================

// Module: downsample_engine
// PURPOSE
//  Memory-mapped image downsampling co-processor for the CPU_COMP system.
//  Reads a WxH source image from byte memory and writes a (W/F)x(H/F) result.
//  Two modes: FxF box average, or decimate (keep the top-left pixel of each tile).
//  Sits beside the CPU on the shared memory port; the CPU grants the port for the whole run.
// PARAMETERS
//  PIX_W   8   pixel / memory data width
//  ADDR_W  16  memory address width
//  DIM_W   8   width of the img_w / img_h runtime dimension inputs
//  LOG2F   1   log2 of the downsample factor F (F = 1<<LOG2F; 0..3 supported)
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       asynchronous, active-high reset
//  start      in   1       one-cycle request; sampled only in IDLE
//  mode       in   1       0 = average, 1 = decimate; sampled at start
//  round_en   in   1       1 = round half-up, 0 = truncate (average mode only); sampled at start
//  src_base   in   ADDR_W  source image base address; sampled at start
//  dst_base   in   ADDR_W  destination base address; sampled at start
//  img_w      in   DIM_W   source width in pixels; sampled at start
//  img_h      in   DIM_W   source height in pixels; sampled at start
//  abort      in   1       synchronous cancel
//  busy       out  1       high from the cycle after start until DONE is left
//  done       out  1       one-cycle pulse when a run completes (not on abort)
//  mem_addr   out  ADDR_W  memory address
//  mem_rd     out  1       read strobe; mem_rdata is valid on the next cycle
//  mem_wr     out  1       write strobe, one cycle per output pixel
//  mem_wdata  out  PIX_W   write data
//  mem_rdata  in   PIX_W   read data, one-cycle synchronous latency
// BEHAVIOUR
//  - Reset (async): state=IDLE. busy, done, mem_rd and mem_wr are 0. mem_addr and mem_wdata are 0.
//    All counters and the accumulator are 0. Reset mid-run discards the run; no further writes occur.
//  - States: IDLE, READ, ACC, WRITE, DONE.
//  - IDLE + start: latch all config inputs and clear ox, oy, kx, ky and acc.
//    If img_w<F or img_h<F, go to DONE (no memory access). Otherwise go to READ.
//  - READ: mem_rd=1. mem_addr = src_base + (oy*F+ky)*img_w + ox*F + kx, computed mod 2^ADDR_W.
//  - ACC: acc += mem_rdata.
//    Average mode: if kx/ky is the last tile position, go to WRITE; else step kx (wrapping into ky) and go to READ.
//    Decimate mode: always go to WRITE after one read.
//  - WRITE: mem_wr=1, mem_addr = dst_base + oy*(img_w>>LOG2F) + ox.
//    Average: mem_wdata = (acc + (round_en ? 1<<(2*LOG2F-1) : 0)) >> 2*LOG2F.
//    Decimate: mem_wdata = the captured pixel.
//    Then clear acc, kx, ky; step ox (wrapping into oy). If this was the last output pixel go to DONE, else READ.
//  - DONE: done=1 for one cycle, then go to IDLE. busy drops in the IDLE cycle.
//  - acc width is PIX_W+2*LOG2F. Rounding can never exceed 2^PIX_W-1, so no saturation logic is needed.
//  - Non-multiple dimensions: trailing img_w mod F columns and img_h mod F rows are never read.
//  - LOG2F=0 (F=1): the block is a plain copy at 3 cycles per pixel.
//  - Cycle cost per output pixel: average = 2*F*F+1, decimate = 3.
//  - start while busy: ignored. abort: from any non-IDLE state go to IDLE next cycle.
//    No done pulse; a WRITE in that same cycle still completes. abort and start together in IDLE: start wins.
//  - mem_rd and mem_wr are never high in the same cycle. mem_addr holds its value when both are low.
// STRUCTURE
//  - ds_pkg: state encoding, MODE_AVG/MODE_DEC constants, and an ACC_W function of PIX_W and LOG2F.
//  - One sub-module, ds_addr_gen: holds the ox/oy/kx/ky counters and the registered row-base
//    address products. It exposes src_addr, dst_addr, tile_last and img_last.
//  - The top level holds the FSM, the accumulator and the memory strobes.
// TESTING
//  - Shared image, 4x4 at src_base 0x0100, dst_base 0x0200, LOG2F=1:
//    rows 10,20,30,40 / 50,60,70,80 / 0,0,255,255 / 1,2,255,254.
//  - Average, truncate -> 0x0200..0x0203 = 35,55,0,254. done pulses exactly 37 clocks after start is sampled.
//  - Average, round_en=1 on the same image -> 35,55,1,255.
//  - Decimate on the same image -> 10,30,0,255. done pulses 13 clocks after start.
//  - Non-multiple and degenerate sizes:
//    5x3 image -> 2 writes, to 0x0200 and 0x0201 only; row 2 and column 4 are never read.
//    img_w=1 -> done the cycle after start, with zero mem strobes.
//  - abort during the second tile -> busy=0 next cycle, no done, exactly 1 write observed.
//    An immediate restart then completes normally.
//  - Reset asserted during an ACC cycle -> all outputs 0 asynchronously. start after release runs cleanly.
//    A start pulsed while busy is ignored: the write count is unchanged.

Source files
------------

// File: rtl/ds_pkg.sv
// rtl/ds_pkg.sv - shared state encoding, mode constants and accumulator sizing for the downsampler
package ds_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_ACC,
    ST_WRITE,
    ST_DONE
  } state_e;

  localparam logic MODE_AVG = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  // A full FxF tile of maximum pixels plus the half-LSB rounding term still fits.
  function automatic int acc_w(input int pix_w, input int log2f);
    return pix_w + 2 * log2f;
  endfunction

endpackage

// File: rtl/ds_addr_gen.sv
// rtl/ds_addr_gen.sv - tile/output counters and incrementally maintained row-base addresses
module ds_addr_gen
  import ds_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 8,
  parameter int LOG2F  = 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] src_base_i,
  input  logic [ADDR_W-1:0] dst_base_i,
  input  logic [DIM_W-1:0]  img_w_i,
  input  logic [DIM_W-1:0]  img_h_i,
  input  logic              step_k_i,
  input  logic              step_o_i,
  output logic [ADDR_W-1:0] src_addr_o,
  output logic [ADDR_W-1:0] dst_addr_o,
  output logic              tile_last_o,
  output logic              img_last_o
);

  localparam int F   = 1 << LOG2F;
  localparam int K_W = (LOG2F == 0) ? 1 : LOG2F;

  logic [K_W-1:0]    kx_q, kx_d, ky_q, ky_d;
  logic [DIM_W-1:0]  ox_q, ox_d, oy_q, oy_d;
  logic [DIM_W-1:0]  img_w_q, img_w_d, out_w_q, out_w_d, out_h_q, out_h_d;
  logic [ADDR_W-1:0] src_tile_q, src_tile_d, src_row_q, src_row_d;
  logic [ADDR_W-1:0] dst_row_q, dst_row_d, col_q, col_d;
  logic              kx_last, ky_last, ox_last, oy_last;
  logic [ADDR_W-1:0] tile_stride;

  assign kx_last     = (kx_q == K_W'(F - 1));
  assign ky_last     = (ky_q == K_W'(F - 1));
  assign ox_last     = (ox_q == out_w_q - DIM_W'(1));
  assign oy_last     = (oy_q == out_h_q - DIM_W'(1));
  assign tile_last_o = kx_last && ky_last;
  assign img_last_o  = ox_last && oy_last;
  assign tile_stride = ADDR_W'(img_w_q) << LOG2F;

  assign src_addr_o = src_row_q + col_q + ADDR_W'(kx_q);
  assign dst_addr_o = dst_row_q + ADDR_W'(ox_q);

  always_comb begin
    kx_d       = kx_q;
    ky_d       = ky_q;
    ox_d       = ox_q;
    oy_d       = oy_q;
    img_w_d    = img_w_q;
    out_w_d    = out_w_q;
    out_h_d    = out_h_q;
    src_tile_d = src_tile_q;
    src_row_d  = src_row_q;
    dst_row_d  = dst_row_q;
    col_d      = col_q;
    if (load_i) begin
      kx_d       = '0;
      ky_d       = '0;
      ox_d       = '0;
      oy_d       = '0;
      img_w_d    = img_w_i;
      out_w_d    = img_w_i >> LOG2F;
      out_h_d    = img_h_i >> LOG2F;
      src_tile_d = src_base_i;
      src_row_d  = src_base_i;
      dst_row_d  = dst_base_i;
      col_d      = '0;
    end else if (step_o_i) begin
      kx_d = '0;
      ky_d = '0;
      if (ox_last) begin
        ox_d       = '0;
        oy_d       = oy_q + DIM_W'(1);
        col_d      = '0;
        src_tile_d = src_tile_q + tile_stride;
        src_row_d  = src_tile_q + tile_stride;
        dst_row_d  = dst_row_q + ADDR_W'(out_w_q);
      end else begin
        ox_d      = ox_q + DIM_W'(1);
        col_d     = col_q + ADDR_W'(F);
        src_row_d = src_tile_q;
      end
    end else if (step_k_i) begin
      if (kx_last) begin
        kx_d      = '0;
        ky_d      = ky_q + K_W'(1);
        src_row_d = src_row_q + ADDR_W'(img_w_q);
      end else begin
        kx_d = kx_q + K_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      kx_q       <= '0;
      ky_q       <= '0;
      ox_q       <= '0;
      oy_q       <= '0;
      img_w_q    <= '0;
      out_w_q    <= '0;
      out_h_q    <= '0;
      src_tile_q <= '0;
      src_row_q  <= '0;
      dst_row_q  <= '0;
      col_q      <= '0;
    end else begin
      kx_q       <= kx_d;
      ky_q       <= ky_d;
      ox_q       <= ox_d;
      oy_q       <= oy_d;
      img_w_q    <= img_w_d;
      out_w_q    <= out_w_d;
      out_h_q    <= out_h_d;
      src_tile_q <= src_tile_d;
      src_row_q  <= src_row_d;
      dst_row_q  <= dst_row_d;
      col_q      <= col_d;
    end
  end

endmodule

// File: rtl/downsample_engine.sv
// rtl/downsample_engine.sv - FSM, accumulator and memory strobes of the image downsampler
module downsample_engine
  import ds_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 8,
  parameter int LOG2F  = 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              mode_i,
  input  logic              round_en_i,
  input  logic [ADDR_W-1:0] src_base_i,
  input  logic [ADDR_W-1:0] dst_base_i,
  input  logic [DIM_W-1:0]  img_w_i,
  input  logic [DIM_W-1:0]  img_h_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rd_o,
  output logic              mem_wr_o,
  output logic [PIX_W-1:0]  mem_wdata_o,
  input  logic [PIX_W-1:0]  mem_rdata_i
);

  localparam int ACC_W = acc_w(PIX_W, LOG2F);
  localparam int F     = 1 << LOG2F;
  localparam logic [ACC_W-1:0] RND = ACC_W'((1 << (2 * LOG2F)) >> 1);

  state_e            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d, avg_sum;
  logic              mode_q, round_q, load;
  logic              step_k, step_o, tile_last, img_last, too_small;
  logic [ADDR_W-1:0] addr_q, src_addr, dst_addr;
  logic [PIX_W-1:0]  wdata_q, avg_pix;

  ds_addr_gen #(
    .ADDR_W(ADDR_W),
    .DIM_W (DIM_W),
    .LOG2F (LOG2F)
  ) u_addr_gen (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (load),
    .src_base_i (src_base_i),
    .dst_base_i (dst_base_i),
    .img_w_i    (img_w_i),
    .img_h_i    (img_h_i),
    .step_k_i   (step_k),
    .step_o_i   (step_o),
    .src_addr_o (src_addr),
    .dst_addr_o (dst_addr),
    .tile_last_o(tile_last),
    .img_last_o (img_last)
  );

  assign too_small = (img_w_i < DIM_W'(F)) || (img_h_i < DIM_W'(F));
  assign avg_sum   = acc_q + (round_q ? RND : '0);
  assign avg_pix   = PIX_W'(avg_sum >> (2 * LOG2F));
  assign busy_o    = (state_q != ST_IDLE);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    load        = 1'b0;
    step_k      = 1'b0;
    step_o      = 1'b0;
    done_o      = 1'b0;
    mem_rd_o    = 1'b0;
    mem_wr_o    = 1'b0;
    mem_addr_o  = addr_q;
    mem_wdata_o = wdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          load    = 1'b1;
          acc_d   = '0;
          state_d = too_small ? ST_DONE : ST_READ;
        end
      end
      ST_READ: begin
        mem_rd_o   = 1'b1;
        mem_addr_o = src_addr;
        state_d    = ST_ACC;
      end
      ST_ACC: begin
        acc_d = acc_q + ACC_W'(mem_rdata_i);
        if (mode_q == MODE_DEC || tile_last) begin
          state_d = ST_WRITE;
        end else begin
          step_k  = 1'b1;
          state_d = ST_READ;
        end
      end
      ST_WRITE: begin
        mem_wr_o    = 1'b1;
        mem_addr_o  = dst_addr;
        // In decimate mode acc was cleared before its single read, so it is the pixel itself.
        mem_wdata_o = (mode_q == MODE_DEC) ? acc_q[PIX_W-1:0] : avg_pix;
        acc_d       = '0;
        step_o      = 1'b1;
        state_d     = img_last ? ST_DONE : ST_READ;
      end
      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort_i && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      done_o  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      mode_q  <= MODE_AVG;
      round_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      addr_q  <= mem_addr_o;
      wdata_q <= mem_wdata_o;
      if (load) begin
        mode_q  <= mode_i;
        round_q <= round_en_i;
      end
    end
  end

endmodule
